// File: rtl/spi_flash_pkg.sv
// -----------------------------------------------------------------------------
// spi_flash_pkg
// Shared definitions for the SPI flash master and the spi_flash_responder:
// opcode constants, frame field lengths and the responder state enum.
// No ports (package).
// -----------------------------------------------------------------------------
package spi_flash_pkg;

   localparam logic [7:0] OP_READ      = 8'h03;
   localparam logic [7:0] OP_FAST_READ = 8'h0B;
   localparam logic [7:0] OP_RDID      = 8'h9F;
   localparam logic [7:0] OP_RDSR      = 8'h05;

   // Serial frame field lengths, in SCLK cycles
   localparam int OPCODE_BITS = 8;
   localparam int ADDR_BITS   = 24;
   localparam int DUMMY_BITS  = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA,
      ST_IGNORE
   } spi_resp_state_t;

endpackage

// File: rtl/spi_flash_responder_if.sv
// -----------------------------------------------------------------------------
// spi_flash_responder_if
// Bundles the SPI pins, the parallel memory write port and the command/status
// outputs of spi_flash_responder.
//   master modport : SPI master / loader side (drives cs, clk, mosi, wr_*)
//   slave modport  : the responder (drives miso, miso_oe, cmd_*, busy)
// Parameter ADDR_W sets the write address width.
// -----------------------------------------------------------------------------
interface spi_flash_responder_if #(
   parameter int ADDR_W = 10
);

   logic              spi_cs;
   logic              spi_clk;
   logic              spi_mosi;
   logic              spi_miso;
   logic              spi_miso_oe;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              cmd_valid;
   logic [7:0]        cmd_code;
   logic              busy;

   modport master (
      output spi_cs, spi_clk, spi_mosi, wr_en, wr_addr, wr_data,
      input  spi_miso, spi_miso_oe, cmd_valid, cmd_code, busy
   );

   modport slave (
      input  spi_cs, spi_clk, spi_mosi, wr_en, wr_addr, wr_data,
      output spi_miso, spi_miso_oe, cmd_valid, cmd_code, busy
   );

endinterface

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Two-flop synchronizer for an asynchronous input followed by an edge
// register that produces single-cycle rise/fall pulses.
//   clk, rst  : system clock, async active-high reset
//   i_async   : asynchronous input
//   o_level   : synchronized level, aligned with the edge pulses
//   o_rise    : one-cycle pulse on a synchronized 0->1 transition
//   o_fall    : one-cycle pulse on a synchronized 1->0 transition
// Parameter RESET_VAL is the idle level of the input (1 for an active-low CS)
// so that leaving reset does not fabricate an edge.
// -----------------------------------------------------------------------------
module spi_sync_edge #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_last;
   logic r_rise;
   logic r_fall;

   // Two sync stages, then a third stage that both delays the level and
   // registers the edge pulses so level and pulses change on the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
         r_last <= RESET_VAL;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_last <= r_sync;
         r_rise <= r_sync & ~r_last;
         r_fall <= ~r_sync & r_last;
      end
   end

   assign o_level = r_last;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/spi_flash_responder.sv
// -----------------------------------------------------------------------------
// spi_flash_responder
// SPI mode-0 flash stand-in. Oversamples cs/clk/mosi in the CLK domain and
// answers READ (0x03), READ-ID (0x9F) and READ-STATUS (0x05) from an internal
// byte array written through a parallel port.
//   CLK, RST : system clock, async active-high reset
//   bus      : spi_flash_responder_if.slave (SPI pins, write port,
//              cmd_valid/cmd_code, busy)
// Parameters: ADDR_W (memory depth 2^ADDR_W), JEDEC_ID, STATUS.
// Optional feature: define SPI_RESP_FAST_READ_EN to accept FAST_READ (0x0B)
// with 8 dummy SCLK cycles; otherwise 0x0B is treated as unknown.
// -----------------------------------------------------------------------------
module spi_flash_responder #(
   parameter int          ADDR_W   = 10,
   parameter logic [23:0] JEDEC_ID = 24'hEF4018,
   parameter logic [7:0]  STATUS   = 8'h00
) (
   input logic                  CLK,
   input logic                  RST,
   spi_flash_responder_if.slave bus
);

   import spi_flash_pkg::*;

   localparam int DEPTH = 1 << ADDR_W;

   spi_resp_state_t r_state;
   spi_resp_state_t w_nextState;

   logic              w_sclkRise;
   logic              w_sclkFall;
   logic              w_unusedSclkLevel;
   logic              w_csLevel;
   logic              w_csRise;
   logic              w_csFall;
   logic              r_mosiMeta;
   logic              r_mosiSync;
   logic [7:0]        w_opcode;
   logic [7:0]        w_nextByte;

   logic [4:0]        r_bitCnt;
   logic [6:0]        r_shiftIn;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_txShift;
   logic [2:0]        r_txCnt;
   logic              r_miso;
   logic [1:0]        r_byteIdx;
   logic              r_cmdValid;
   logic [7:0]        r_cmdCode;
   logic [7:0]        r_memData;
   logic [7:0]        r_mem [DEPTH];

   spi_sync_edge #(.RESET_VAL(1'b0)) u_sclkSync (
      .clk     (CLK),
      .rst     (RST),
      .i_async (bus.spi_clk),
      .o_level (w_unusedSclkLevel),
      .o_rise  (w_sclkRise),
      .o_fall  (w_sclkFall)
   );

   spi_sync_edge #(.RESET_VAL(1'b1)) u_csSync (
      .clk     (CLK),
      .rst     (RST),
      .i_async (bus.spi_cs),
      .o_level (w_csLevel),
      .o_rise  (w_csRise),
      .o_fall  (w_csFall)
   );

   // MOSI only needs to be stable when the SCLK rise pulse arrives; the master
   // holds it for a full half period, so a plain two-flop sync is enough.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_mosiMeta <= 1'b0;
         r_mosiSync <= 1'b0;
      end else begin
         r_mosiMeta <= bus.spi_mosi;
         r_mosiSync <= r_mosiMeta;
      end
   end

   assign w_opcode = {r_shiftIn, r_mosiSync};

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= ST_IDLE;
      else     r_state <= w_nextState;
   end

   // Next-state decode. CS high wins over everything; the opcode is decoded
   // from the shift register plus the bit arriving on the completing edge.
   always_comb begin
      w_nextState = r_state;
      if (w_csLevel) begin
         w_nextState = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_csFall) w_nextState = ST_CMD;
            end
            ST_CMD: begin
               if (w_sclkRise && (r_bitCnt == 5'(OPCODE_BITS - 1))) begin
                  case (w_opcode)
                     OP_READ:          w_nextState = ST_ADDR;
`ifdef SPI_RESP_FAST_READ_EN
                     OP_FAST_READ:     w_nextState = ST_ADDR;
`endif
                     OP_RDID, OP_RDSR: w_nextState = ST_DATA;
                     default:          w_nextState = ST_IGNORE;
                  endcase
               end
            end
            ST_ADDR: begin
               if (w_sclkRise && (r_bitCnt == 5'(ADDR_BITS - 1))) begin
`ifdef SPI_RESP_FAST_READ_EN
                  if (r_cmdCode == OP_FAST_READ) w_nextState = ST_DUMMY;
                  else                           w_nextState = ST_DATA;
`else
                  w_nextState = ST_DATA;
`endif
               end
            end
            ST_DUMMY: begin
               if (w_sclkRise && (r_bitCnt == 5'(DUMMY_BITS - 1))) w_nextState = ST_DATA;
            end
            default: w_nextState = r_state;
         endcase
      end
   end

   // Byte to start shifting on the next byte boundary. READ uses the
   // prefetched memory word; READ-ID walks the JEDEC bytes then pads zeros.
   always_comb begin
      w_nextByte = r_memData;
      if (r_cmdCode == OP_RDID) begin
         case (r_byteIdx)
            2'd0:    w_nextByte = JEDEC_ID[23:16];
            2'd1:    w_nextByte = JEDEC_ID[15:8];
            2'd2:    w_nextByte = JEDEC_ID[7:0];
            default: w_nextByte = 8'h00;
         endcase
      end else if (r_cmdCode == OP_RDSR) begin
         w_nextByte = STATUS;
      end
   end

   // Serial datapath. The CS rise pulse clears the counters one cycle before
   // the FSM reaches IDLE so an aborted partial byte never survives. In DATA
   // a new byte is taken on the first fall of each byte, which is the fall
   // right after the last header bit, so the MSB is out before the next rise.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_bitCnt   <= '0;
         r_shiftIn  <= '0;
         r_addr     <= '0;
         r_txShift  <= '0;
         r_txCnt    <= '0;
         r_miso     <= 1'b0;
         r_byteIdx  <= '0;
         r_cmdValid <= 1'b0;
         r_cmdCode  <= '0;
      end else begin
         r_cmdValid <= 1'b0;
         if (w_csRise || (r_state == ST_IDLE)) begin
            r_bitCnt  <= '0;
            r_shiftIn <= '0;
            r_txCnt   <= '0;
            r_miso    <= 1'b0;
            r_byteIdx <= '0;
         end else begin
            case (r_state)
               ST_CMD: begin
                  if (w_sclkRise) begin
                     r_shiftIn <= w_opcode[6:0];
                     if (r_bitCnt == 5'(OPCODE_BITS - 1)) begin
                        r_bitCnt   <= '0;
                        r_cmdValid <= 1'b1;
                        r_cmdCode  <= w_opcode;
                     end else begin
                        r_bitCnt <= r_bitCnt + 5'd1;
                     end
                  end
               end
               ST_ADDR: begin
                  if (w_sclkRise) begin
                     r_addr <= {r_addr[ADDR_W-2:0], r_mosiSync};
                     if (r_bitCnt == 5'(ADDR_BITS - 1)) r_bitCnt <= '0;
                     else                               r_bitCnt <= r_bitCnt + 5'd1;
                  end
               end
               ST_DUMMY: begin
                  if (w_sclkRise) begin
                     if (r_bitCnt == 5'(DUMMY_BITS - 1)) r_bitCnt <= '0;
                     else                                r_bitCnt <= r_bitCnt + 5'd1;
                  end
               end
               ST_DATA: begin
                  if (w_sclkFall) begin
                     if (r_txCnt == 3'd0) begin
                        r_miso    <= w_nextByte[7];
                        r_txShift <= {w_nextByte[6:0], 1'b0};
                        r_addr    <= r_addr + 1'b1;
                        if (r_byteIdx != 2'd3) r_byteIdx <= r_byteIdx + 2'd1;
                     end else begin
                        r_miso    <= r_txShift[7];
                        r_txShift <= {r_txShift[6:0], 1'b0};
                     end
                     r_txCnt <= r_txCnt + 3'd1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Memory array: no reset so contents survive RST. The read is registered
   // every cycle from the current address, which keeps the next byte
   // prefetched and lets a write to that address be picked up before it is
   // consumed, while the byte already in r_txShift is untouched.
   always_ff @(posedge CLK) begin
      if (bus.wr_en) r_mem[bus.wr_addr] <= bus.wr_data;
      r_memData <= r_mem[r_addr];
   end

   assign bus.spi_miso_oe = (r_state == ST_DATA);
   assign bus.spi_miso    = r_miso & (r_state == ST_DATA);
   assign bus.cmd_valid   = r_cmdValid;
   assign bus.cmd_code    = r_cmdCode;
   assign bus.busy        = ~w_csLevel;

endmodule

// File: tb/tb_spi_flash_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_responder
// Directed bench for spi_flash_responder: a mode-0 SPI master task drives
// transactions, a memory/ID/status model gives the expected MISO stream, and
// a compare process checks miso/miso_oe during every settled SCLK-low phase.
// Honours SPI_RESP_FAST_READ_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_spi_flash_responder;

   import spi_flash_pkg::*;

   localparam int          ADDR_W = 10;
   localparam int          DEPTH  = 1 << ADDR_W;
   localparam int          HALF   = 8;
   localparam logic [23:0] JEDEC  = 24'hEF4018;
   localparam logic [7:0]  STAT   = 8'h00;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   spi_flash_responder_if #(.ADDR_W(ADDR_W)) bus ();

   spi_flash_responder #(
      .ADDR_W   (ADDR_W),
      .JEDEC_ID (JEDEC),
      .STATUS   (STAT)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   int         nTests  = 0;
   int         nFails  = 0;
   int         cvCount = 0;
   logic       chkEn   = 1'b0;
   logic       expOe   = 1'b0;
   logic       expMiso = 1'b0;
   logic [7:0] memModel [DEPTH];
   logic [7:0] rxQ [$];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nTests++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Header length (bits before data) that the responder should honour, or
   // -1 when the opcode must never produce data.
   function automatic int modelHdr(input logic [7:0] op);
      case (op)
         OP_READ:          return 32;
`ifdef SPI_RESP_FAST_READ_EN
         OP_FAST_READ:     return 40;
`endif
         OP_RDID, OP_RDSR: return 8;
         default:          return -1;
      endcase
   endfunction

   // Header length the master actually sends on the wire.
   function automatic int streamHdr(input logic [7:0] op);
      if (op == OP_READ)      return 32;
      if (op == OP_FAST_READ) return 40;
      return 8;
   endfunction

   function automatic logic [7:0] modelByte(input logic [7:0] op, input logic [23:0] addr, input int idx);
      logic [23:0] sh;
      if (op == OP_READ || op == OP_FAST_READ) return memModel[(int'(addr) + idx) % DEPTH];
      if (op == OP_RDID) begin
         if (idx >= 3) return 8'h00;
         sh = JEDEC >> (8 * (2 - idx));
         return sh[7:0];
      end
      return STAT;
   endfunction

   // Compare process: counts cmd_valid pulses and checks the MISO pins
   // whenever the master marks the current phase as settled.
   always @(negedge clk) begin
      if (bus.cmd_valid) cvCount++;
      if (chkEn) begin
         checkOutput("miso_oe", 32'(bus.spi_miso_oe), 32'(expOe));
         checkOutput("miso", 32'(bus.spi_miso), 32'(expMiso));
      end
   end

   task automatic writeMem(input logic [ADDR_W-1:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      memModel[a] = d;
      @(negedge clk);
      bus.wr_en   = 1'b0;
   endtask

   // One SPI transaction: opcode, address/dummy as the opcode implies on the
   // wire, then nBytes of data clocks. cutBits>0 raises CS after that many
   // SCLK cycles. Received data bytes are left in rxQ.
   task automatic applyStimulus(input logic [7:0] op, input logic [23:0] addr, input int nBytes, input int cutBits);
      int          sh;
      int          mh;
      int          total;
      int          j;
      int          rxCnt;
      logic [39:0] hdrBits;
      logic [7:0]  b;
      logic [7:0]  rxByte;
      sh      = streamHdr(op);
      mh      = modelHdr(op);
      total   = (cutBits > 0) ? cutBits : sh + 8 * nBytes;
      hdrBits = {op, addr, 8'h00};
      rxQ.delete();
      cvCount = 0;
      rxCnt   = 0;
      rxByte  = 8'h00;
      @(posedge clk);
      bus.spi_cs = 1'b0;
      repeat (6) @(posedge clk);
      checkOutput("busy_active", 32'(bus.busy), 32'd1);
      for (int k = 0; k < total; k++) begin
         bus.spi_mosi = (k < sh) ? hdrBits[39 - k] : 1'b0;
         if (mh >= 0 && k >= mh) begin
            j       = k - mh;
            b       = modelByte(op, addr, j / 8);
            expOe   = 1'b1;
            expMiso = b[7 - (j % 8)];
         end else begin
            expOe   = 1'b0;
            expMiso = 1'b0;
         end
         repeat (5) @(posedge clk);
         chkEn = 1'b1;
         repeat (HALF - 5) @(posedge clk);
         chkEn = 1'b0;
         if (k >= sh) begin
            rxByte = {rxByte[6:0], bus.spi_miso};
            rxCnt++;
            if (rxCnt == 8) begin
               rxQ.push_back(rxByte);
               rxCnt = 0;
            end
         end
         bus.spi_clk = 1'b1;
         repeat (HALF) @(posedge clk);
         bus.spi_clk = 1'b0;
      end
      repeat (HALF) @(posedge clk);
      bus.spi_cs = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      checkOutput("idle_oe", 32'(bus.spi_miso_oe), 32'd0);
      checkOutput("idle_miso", 32'(bus.spi_miso), 32'd0);
      checkOutput("idle_busy", 32'(bus.busy), 32'd0);
      checkOutput("cmd_valid_count", 32'(cvCount), (total >= 8) ? 32'd1 : 32'd0);
      if (total >= 8) checkOutput("cmd_code", 32'(bus.cmd_code), 32'(op));
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst          = 1'b1;
      bus.spi_cs   = 1'b1;
      bus.spi_clk  = 1'b0;
      bus.spi_mosi = 1'b0;
      bus.wr_en    = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      for (int i = 0; i < DEPTH; i++) memModel[i] = 8'h00;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_miso", 32'(bus.spi_miso), 32'd0);
      checkOutput("rst_oe", 32'(bus.spi_miso_oe), 32'd0);
      checkOutput("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
      checkOutput("rst_cmd_code", 32'(bus.cmd_code), 32'd0);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      repeat (4) @(posedge clk);

      writeMem(10'h010, 8'hAA);
      writeMem(10'h011, 8'h55);
      writeMem(10'h3FF, 8'h12);
      writeMem(10'h000, 8'h34);

      $display("[TB] READ at 0x000010");
      applyStimulus(OP_READ, 24'h000010, 2, 0);
      checkOutput("read_b0", 32'(rxQ[0]), 32'hAA);
      checkOutput("read_b1", 32'(rxQ[1]), 32'h55);

      $display("[TB] READ-ID");
      applyStimulus(OP_RDID, 24'h0, 4, 0);
      checkOutput("rdid_b0", 32'(rxQ[0]), 32'hEF);
      checkOutput("rdid_b1", 32'(rxQ[1]), 32'h40);
      checkOutput("rdid_b2", 32'(rxQ[2]), 32'h18);
      checkOutput("rdid_b3", 32'(rxQ[3]), 32'h00);

      $display("[TB] READ wrap at 0x0003FF");
      applyStimulus(OP_READ, 24'h0003FF, 2, 0);
      checkOutput("wrap_b0", 32'(rxQ[0]), 32'h12);
      checkOutput("wrap_b1", 32'(rxQ[1]), 32'h34);

      $display("[TB] READ aborted after 12 address bits");
      applyStimulus(OP_READ, 24'h000010, 0, 20);
      applyStimulus(OP_READ, 24'h000010, 1, 0);
      checkOutput("after_abort_b0", 32'(rxQ[0]), 32'hAA);

      $display("[TB] unknown opcode 0x06");
      applyStimulus(8'h06, 24'h0, 1, 0);
      checkOutput("unknown_rx", 32'(rxQ[0]), 32'h00);

      $display("[TB] READ-STATUS");
      applyStimulus(OP_RDSR, 24'h0, 2, 0);
      checkOutput("rdsr_b0", 32'(rxQ[0]), 32'h00);
      checkOutput("rdsr_b1", 32'(rxQ[1]), 32'h00);

      $display("[TB] FAST_READ at 0x000010");
      applyStimulus(OP_FAST_READ, 24'h000010, 1, 0);
`ifdef SPI_RESP_FAST_READ_EN
      checkOutput("fast_b0", 32'(rxQ[0]), 32'hAA);
`else
      checkOutput("fast_off_rx", 32'(rxQ[0]), 32'h00);
`endif

      $display("[TB] CS pulse without SCLK");
      cvCount = 0;
      @(posedge clk);
      bus.spi_cs = 1'b0;
      repeat (20) @(posedge clk);
      bus.spi_cs = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      checkOutput("cs_only_cmd_valid", 32'(cvCount), 32'd0);
      checkOutput("cs_only_cmd_code", 32'(bus.cmd_code), 32'(OP_FAST_READ));

      $display("[TB] %0d tests run, %0d failed", nTests, nFails);
      $finish;
   end

endmodule
